// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
// Ratios below MIN_RATIO mark a channel as disabled; high_time gives the
// number of high cycles per period (the extra cycle of an odd ratio goes high).
package clk_div_pkg;

    localparam int CNT_W_DEF = 6;
    localparam int MIN_RATIO = 2;

    // Cycles per period that div_out stays high: ceil(n/2)
    function automatic int unsigned high_time(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

    // A ratio is usable only when it divides by at least MIN_RATIO
    function automatic logic ratio_ok(input int unsigned n);
        return (n >= MIN_RATIO);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow ratio and registered
// div_out/tc. Start, sync and enable-clear decisions are made by the bank
// and shared by all channels, so every channel moves on the same edge.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en_clr,
    input  logic             start,
    input  logic             sync,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] ratio_in,
    output logic             div_out,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_reg,  cnt_next;
    logic [CNT_W-1:0] act_reg,  act_next;
    logic [CNT_W-1:0] shd_reg,  shd_next;
    logic             pend_reg, pend_next;
    logic             div_reg,  div_next;
    logic             tc_reg,   tc_next;

    logic [CNT_W-1:0] shd_eff;
    logic             pend_eff;
    logic             act_ok;
    logic             new_ok;
    logic             wrap;
    logic             apply;
    logic             restart;
    logic [CNT_W-1:0] ht;

    // Ratio bookkeeping and the next counter/output values for this edge
    always_comb begin
        // A load sampled on this edge already counts, so a load during the
        // last cycle of a period (or alongside sync) takes effect right away.
        shd_eff  = load ? ratio_in : shd_reg;
        pend_eff = load | pend_reg;
        act_ok   = ratio_ok(32'(act_reg));

        // The counter only ever holds values below act_reg, so equality
        // with act_reg-1 is the last cycle of the period.
        wrap = run & act_ok & ~en_clr & (cnt_reg == (act_reg - 1'b1));

        // A disabled channel takes its shadow immediately, even while the
        // bank is idle, so ratios programmed with en low are ready at Start.
        apply = pend_eff & (~act_ok | (~en_clr & (sync | wrap)));

        act_next  = apply ? shd_eff : act_reg;
        shd_next  = shd_eff;
        pend_next = pend_eff & ~apply;

        new_ok  = ratio_ok(32'(act_next));
        ht      = CNT_W'(high_time(32'(act_next)));
        // A channel waking from disabled while the bank runs starts on its
        // own; it rejoins the common phase at the next sync.
        restart = start | sync | (run & ~act_ok);

        cnt_next = '0;
        div_next = 1'b0;
        tc_next  = 1'b0;
        if (en_clr || !new_ok) begin
            cnt_next = '0;
            div_next = 1'b0;
            tc_next  = 1'b0;
        end else if (restart) begin
            cnt_next = '0;
            div_next = 1'b1;
            tc_next  = 1'b1;
        end else if (run) begin
            cnt_next = wrap ? '0 : (cnt_reg + 1'b1);
            div_next = (cnt_next < ht);
            tc_next  = (cnt_next == '0);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg  <= '0;
            act_reg  <= '0;
            shd_reg  <= '0;
            pend_reg <= 1'b0;
            div_reg  <= 1'b0;
            tc_reg   <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            act_reg  <= act_next;
            shd_reg  <= shd_next;
            pend_reg <= pend_next;
            div_reg  <= div_next;
            tc_reg   <= tc_next;
        end
    end

    assign div_out = div_reg;
    assign tc      = tc_reg;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH integer clock dividers sharing one reference clock.
// The bank tracks whether the dividers are running and turns en/sync into
// the common start, sync and clear controls so channels stay phase-aligned.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    en,
    input  logic [NUM_CH*CNT_W-1:0] ratio,
    input  logic [NUM_CH-1:0]       load,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       div_out,
    output logic [NUM_CH-1:0]       tc
);

    logic run_reg;
    logic start;
    logic sync_go;
    logic en_clr;

    // Shared control decode: first enabled edge after idle is a Start
    always_comb begin
        en_clr  = ~en;
        start   = en & ~run_reg;
        sync_go = en & sync;
    end

    // Run flag follows en one edge later, so a rising en yields one Start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= en;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            clk_div_chan #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk      (clk),
                .resetn   (resetn),
                .en_clr   (en_clr),
                .start    (start),
                .sync     (sync_go),
                .run      (run_reg),
                .load     (load[gi]),
                .ratio_in (ratio[gi*CNT_W +: CNT_W]),
                .div_out  (div_out[gi]),
                .tc       (tc[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank. The reference model tracks, per
// channel, the edge on which the current period began and derives div_out/tc
// from elapsed time modulo the ratio.
module tb_clk_div_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 6;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    en = 1'b0;
    logic                    sync = 1'b0;
    logic [NUM_CH*CNT_W-1:0] ratio = '0;
    logic [NUM_CH-1:0]       load = '0;
    logic [NUM_CH-1:0]       div_out;
    logic [NUM_CH-1:0]       tc;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model state
    int m_act [NUM_CH];
    int m_shd [NUM_CH];
    int m_t0  [NUM_CH];
    bit m_pend[NUM_CH];
    bit m_on  [NUM_CH];
    bit m_run;
    bit exp_div[NUM_CH];
    bit exp_tc [NUM_CH];

    clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .en      (en),
        .ratio   (ratio),
        .load    (load),
        .sync    (sync),
        .div_out (div_out),
        .tc      (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (edge %0d)", tag, got, want, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c] = 0; m_shd[c] = 0; m_t0[c] = 0;
            m_pend[c] = 0; m_on[c] = 0;
            exp_div[c] = 0; exp_tc[c] = 0;
        end
        m_run = 0;
    endtask

    // Predict the outputs after the coming edge from the current inputs
    task automatic model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            int  se;
            bit  pe, old_ok, bnd, apply;
            se     = load[c] ? int'(ratio[c*CNT_W +: CNT_W]) : m_shd[c];
            pe     = load[c] | m_pend[c];
            old_ok = (m_act[c] >= 2);
            bnd    = m_on[c] && old_ok && (((edge_n - m_t0[c]) % m_act[c]) == 0);
            if (!en) apply = pe && !old_ok;
            else     apply = pe && (!old_ok || sync || bnd);
            m_shd[c] = se;
            if (apply) begin
                m_act[c]  = se;
                m_pend[c] = 0;
            end else begin
                m_pend[c] = pe;
            end
            if (!en || m_act[c] < 2) begin
                m_on[c] = 0;
            end else if (!m_run || sync || !old_ok) begin
                m_on[c] = 1;
                m_t0[c] = edge_n;
            end else if (bnd && apply) begin
                m_t0[c] = edge_n;
            end
            if (m_on[c]) begin
                int p;
                p = (edge_n - m_t0[c]) % m_act[c];
                exp_div[c] = (p < (m_act[c] + 1) / 2);
                exp_tc[c]  = (p == 0);
            end else begin
                exp_div[c] = 0;
                exp_tc[c]  = 0;
            end
        end
        m_run = en;
    endtask

    // One clock: predict, clock, compare, then drop the strobes
    task automatic step();
        if (resetn) model_edge();
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("div%0d", c), 32'(div_out[c]), 32'(exp_div[c]));
            check($sformatf("tc%0d", c),  32'(tc[c]),      32'(exp_tc[c]));
        end
        $display("edge %0d en=%0b sync=%0b load=%b div_out=%b tc=%b",
                 edge_n, en, sync, load, div_out, tc);
        edge_n++;
        load = '0;
        sync = 1'b0;
    endtask

    task automatic set_ratio(input int c, input int r);
        ratio[c*CNT_W +: CNT_W] = CNT_W'(r);
        load[c] = 1'b1;
    endtask

    initial begin
        int first_co;
        model_reset();

        // Reset state
        for (int i = 0; i < 3; i++) step();
        check("rst_div", 32'(div_out), 32'd0);
        check("rst_tc",  32'(tc),      32'd0);
        resetn = 1'b1;

        // Even ratios 2/4/6 programmed while idle, then a common Start
        set_ratio(0, 2); set_ratio(1, 4); set_ratio(2, 6);
        step();
        en = 1'b1;
        first_co = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tc == 3'b111) begin
                if (first_co < 0) first_co = i;
                else if (i < first_co + 13) check("tc_coincide", 32'(i - first_co), 32'd12);
            end
        end
        check("start_edge", 32'(first_co), 32'd0);

        // Odd ratios
        en = 1'b0; set_ratio(0, 3); set_ratio(1, 5); set_ratio(2, 7);
        step();
        en = 1'b1;
        for (int i = 0; i < 40; i++) step();

        // Mid-period reload on channel 0, overwritten before the wrap
        en = 1'b0; set_ratio(0, 4);
        step();
        en = 1'b1;
        step();                      // Start, cnt=0
        step();                      // cnt=1
        set_ratio(0, 6); step();
        set_ratio(0, 8); step();
        for (int i = 0; i < 30; i++) step();

        // Desynchronise channel 1 then realign everything with sync
        set_ratio(0, 4); set_ratio(1, 6);
        for (int i = 0; i < 10; i++) step();
        set_ratio(1, 5);
        for (int i = 0; i < 9; i++) step();
        set_ratio(1, 6); sync = 1'b1;
        step();
        check("sync_div", 32'(div_out[1:0]), 32'd3);
        check("sync_tc",  32'(tc[1:0]),      32'd3);
        for (int i = 0; i < 20; i++) step();

        // Disabled ratios 0 and 1, then wake channel 2 with ratio 2
        set_ratio(2, 0);
        for (int i = 0; i < 8; i++) step();
        set_ratio(2, 1);
        for (int i = 0; i < 5; i++) step();
        check("dis_div", 32'(div_out[2]), 32'd0);
        set_ratio(2, 2);
        step();
        check("wake_div", 32'(div_out[2]), 32'd1);
        for (int i = 0; i < 6; i++) step();

        // en dropped mid-period, then re-enabled
        for (int i = 0; i < 3; i++) step();
        en = 1'b0;
        step();
        check("en_off", 32'(div_out), 32'd0);
        en = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Asynchronous reset mid-period
        #2 resetn = 1'b0;
        #1 check("async_div", 32'(div_out), 32'd0);
        check("async_tc", 32'(tc), 32'd0);
        model_reset();
        #1 resetn = 1'b1;
        en = 1'b0; set_ratio(0, 63); set_ratio(1, 2); set_ratio(2, 9);
        step();
        en = 1'b1;
        for (int i = 0; i < 140; i++) step();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            en   = ($urandom_range(0, 99) < 96);
            sync = ($urandom_range(0, 99) < 3);
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 99) < 5) set_ratio(c, int'($urandom_range(0, 63)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
